// File: rtl/pes_fb_sipo_rx_if.sv
// Serial receive / word output bundle for the SIPO receiver.
// master drives the serial side and ready, slave is the receiver.
interface pes_fb_sipo_rx_if #(
  parameter int WIDTH = 4
);
  logic             ser_in;
  logic             ser_en;
  logic             sync;
  logic             data_ready;
  logic             clr_ovr;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             overrun;
  logic             frame_err;

  modport master (
    output ser_in, ser_en, sync,
    output data_ready, clr_ovr,
    input  data_out, data_valid,
    input  overrun, frame_err
  );

  modport slave (
    input  ser_in, ser_en, sync,
    input  data_ready, clr_ovr,
    output data_out, data_valid,
    output overrun, frame_err
  );
endinterface

// File: rtl/pes_fb_sipo_rx.sv
// SIPO receiver: sync-aligned word assembly with a
// valid/ready output register, sticky overrun, framing pulse.
module pes_fb_sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst_n,
  pes_fb_sipo_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] first_d;
  logic [WIDTH-1:0] dout_q;
  logic             vld_q;
  logic             ovr_q;
  logic             ferr_q;
  logic             start;
  logic             take;
  logic             last;
  logic             done;
  logic             xfer;

  always_comb begin
    first_d = '0;
    sh_d    = '0;
    if (MSB_FIRST) begin
      first_d = {{(WIDTH-1){1'b0}}, bus.ser_in};
      sh_d    = {sh_q[WIDTH-2:0], bus.ser_in};
    end else begin
      first_d = {bus.ser_in, {(WIDTH-1){1'b0}}};
      sh_d    = {bus.ser_in, sh_q[WIDTH-1:1]};
    end
    start = bus.ser_en & bus.sync;
    take  = (state_q == SHIFT) & bus.ser_en
          & ~bus.sync;
    last  = (cnt_q == CW'(WIDTH - 1));
    done  = take & last;
    xfer  = vld_q & bus.data_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      // a sync while already in a word aborts it
      ferr_q <= (state_q == SHIFT) & start;

      if (start) begin
        sh_q    <= first_d;
        cnt_q   <= CW'(1);
        state_q <= SHIFT;
      end else if (take) begin
        sh_q <= sh_d;
        if (last) begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      if (done && (!vld_q || bus.data_ready)) begin
        dout_q <= sh_d;
        vld_q  <= 1'b1;
      end else if (xfer) begin
        vld_q <= 1'b0;
      end

      // set wins over a simultaneous clear
      if (done && vld_q && !bus.data_ready) begin
        ovr_q <= 1'b1;
      end else if (bus.clr_ovr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.data_valid = vld_q;
  assign bus.overrun    = ovr_q;
  assign bus.frame_err  = ferr_q;
endmodule
